// File: rtl/riscv32_prefetch_pkg.sv
// Shared defaults for the RV32 prefetch unit: data width, queue depth and
// the post-reset fetch address, plus a helper that word-aligns an address.
package riscv32_prefetch_pkg;

  localparam int XLEN = 32;
  localparam int PF_DEPTH = 4;
  localparam logic [XLEN-1:0] PF_RESET_PC = 32'h0000_0000;

  // Instructions are 32-bit words; the two low address bits are always zero.
  function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/riscv32_pf_fifo.sv
// Instruction queue for the prefetch unit. Each entry is {instr, pc}.
// The head entry is read combinationally; push and pop happen at the edge.
// A flush empties the queue in one cycle by clearing count and pointers.
module riscv32_pf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         headData,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head slot is always visible; the caller qualifies it with count.
  always_comb begin
    headData = mem[rdPtr];
  end

endmodule

// File: rtl/riscv32_prefetch.sv
// RV32 instruction prefetch unit. Fetches one word per cycle from a
// combinational ROM into a small queue and presents the queue head to the
// core. A redirect flushes the queue and restarts fetch at the new target.
//
// Handshake: the head is offered with oINSTR_VALID and taken by the core in
// any cycle where oINSTR_VALID and iINSTR_READY are both high; while valid
// is high and ready is low, the head word, its pc and valid stay stable.
module riscv32_prefetch
  import riscv32_prefetch_pkg::*;
#(
  parameter int          DEPTH    = PF_DEPTH,
  parameter logic [31:0] RESET_PC = PF_RESET_PC
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  output logic                   oROM_CE,
  output logic                   oROM_RD,
  output logic [7:0]             oROM_ADDR,
  input  logic [31:0]            iROM_DATA,
  input  logic                   iREDIRECT,
  input  logic [31:0]            iREDIRECT_PC,
  output logic                   oINSTR_VALID,
  output logic [31:0]            oINSTR,
  output logic [31:0]            oINSTR_PC,
  input  logic                   iINSTR_READY,
  output logic [$clog2(DEPTH):0] oCOUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [XLEN-1:0] fetchPc;
  logic            fetchCycle;
  logic            popCycle;
  logic            instrValid;
  logic [AW:0]     count;
  logic [63:0]     headData;
  logic [63:0]     pushData;

  // Head qualification, pop detection and fetch enable. A redirect blocks
  // both the pop and the fetch so nothing from the old stream survives.
  always_comb begin
    instrValid = (count != '0) && !iREDIRECT;
    popCycle   = instrValid && iINSTR_READY;
    fetchCycle = iRST && !iREDIRECT && ((count < FULL_COUNT) || popCycle);
    pushData   = {iROM_DATA, fetchPc};
  end

  // Fetch address: restart at the redirect target, advance after a fetch,
  // otherwise hold (queue full with no pop). Wraps at the top of memory.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      fetchPc <= alignPc(RESET_PC);
    end else if (iREDIRECT) begin
      fetchPc <= alignPc(iREDIRECT_PC);
    end else if (fetchCycle) begin
      fetchPc <= fetchPc + 32'd4;
    end
  end

  riscv32_pf_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) uFifo (
    .clk      (iCLK),
    .rstN     (iRST),
    .flush    (iREDIRECT),
    .push     (fetchCycle),
    .pushData (pushData),
    .pop      (popCycle),
    .headData (headData),
    .count    (count)
  );

  // Output mapping: ROM strobes follow the fetch enable, head splits into
  // instruction word and its byte address.
  always_comb begin
    oROM_CE      = fetchCycle;
    oROM_RD      = fetchCycle;
    oROM_ADDR    = fetchPc[7:0];
    oINSTR_VALID = instrValid;
    oINSTR       = headData[63:32];
    oINSTR_PC    = headData[31:0];
    oCOUNT       = count;
  end

endmodule
